seq_generator: RTL and testbench

- Serial pattern transmitter: drives a programmable fixed-width bit pattern onto a 1-bit stream, MSB first, one bit per clock.
- On a start request it sends a requested number of back-to-back or gapped repetitions.
- It is the stimulus/transmit side for the team's serial sequence detectors; a default pattern of 0110 matches the existing detector.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_generator.sv | 137 +++++++++++++
 tb/tb_seq_generator.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_gen_pkg;

    // Transmitter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP_ST = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Pattern expected by the existing 0110 sequence detector
    localparam int unsigned    DEFAULT_PAT_W   = 4;
    localparam logic [3:0]     DEFAULT_PATTERN = 4'b0110;

    // Odd-parity bit: makes the total count of ones (data + parity) odd.
    // Zero-extension of narrower patterns does not change the result.
    function automatic logic odd_parity(input logic [63:0] value);
        return ~(^value);
    endfunction

endpackage

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends PATTERN MSB-first, one bit per clock,
// repeated a latched number of times with GAP idle cycles between repetitions.
// Optional build macro PARITY_EN appends an odd-parity bit after each pattern.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned       PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int unsigned       GAP     = 1,
    parameter int unsigned       CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]   r_rep_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_x;
    logic               r_x_valid;
    logic               r_busy;
    logic               r_done;
`ifdef PARITY_EN
    logic               r_par_phase;
`endif

    // Sequencer: state, counters and registered (Moore) outputs together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_idx   <= '0;
            r_rep_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PARITY_EN
            r_par_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SEND;
                        r_rep_cnt <= (reps == '0) ? CNT_W'(1) : reps;
                        r_bit_idx <= IDX_MSB;
                        r_x       <= PATTERN[PAT_W-1];
                        r_x_valid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                SEND: begin
                    if (r_bit_idx != '0) begin
                        // Mid-pattern: advance to the next lower bit
                        r_bit_idx <= r_bit_idx - IDX_W'(1);
                        r_x       <= PATTERN[r_bit_idx - IDX_W'(1)];
                    end
`ifdef PARITY_EN
                    else if (!r_par_phase) begin
                        // LSB just went out: parity bit takes one more valid cycle
                        r_par_phase <= 1'b1;
                        r_x         <= odd_parity(64'(PATTERN));
                    end
`endif
                    else begin
`ifdef PARITY_EN
                        r_par_phase <= 1'b0;
`endif
                        if (r_rep_cnt > CNT_W'(1)) begin
                            // More repetitions pending: rewind to the MSB
                            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
                            r_bit_idx <= IDX_MSB;
                            if (GAP > 0) begin
                                r_state   <= GAP_ST;
                                r_gap_cnt <= GAP_W'(GAP - 1);
                                r_x       <= 1'b0;
                                r_x_valid <= 1'b0;
                            end else begin
                                r_x       <= PATTERN[PAT_W-1];
                            end
                        end else begin
                            r_state   <= DONE;
                            r_x       <= 1'b0;
                            r_x_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end

                GAP_ST: begin
                    // Hold the line idle for GAP cycles, then resume with the MSB
                    if (r_gap_cnt == '0) begin
                        r_state   <= SEND;
                        r_x       <= PATTERN[PAT_W-1];
                        r_x_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state   <= IDLE;
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Output ports driven straight from their registers
    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: three instances (default, gapless,
// long gap) driven by shared stimulus and checked every cycle against an
// arithmetic model of the output stream. Honours PARITY_EN like the RTL.
module tb_seq_generator;

`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] reps;

    logic x0, v0, b0, d0;
    logic x1, v1, b1, d1;
    logic x2, v2, b2, d2;

    int total = 0;
    int bad   = 0;

    // Instance 0 uses all defaults: 0110, GAP=1
    seq_generator u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .reps(reps),
        .x(x0), .x_valid(v0), .busy(b0), .done(d0)
    );

    seq_generator #(.PAT_W(5), .PATTERN(5'b10011), .GAP(0), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .reps(reps),
        .x(x1), .x_valid(v1), .busy(b1), .done(d1)
    );

    seq_generator #(.PAT_W(3), .PATTERN(3'b100), .GAP(3), .CNT_W(4)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start), .reps(reps),
        .x(x2), .x_valid(v2), .busy(b2), .done(d2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int pw(input int i);
        case (i)
            0: return 4;
            1: return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int pat(input int i);
        case (i)
            0: return 'b0110;
            1: return 'b10011;
            default: return 'b100;
        endcase
    endfunction

    function automatic int gp(input int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int par_bit(input int i);
        int ones;
        ones = 0;
        for (int b = 0; b < pw(i); b++) ones += (pat(i) >> b) & 1;
        return (ones % 2 == 0) ? 1 : 0;
    endfunction

    // Busy length of a burst of n repetitions
    function automatic int burst_len(input int i, input int n);
        return n * (pw(i) + PAR) + (n - 1) * gp(i);
    endfunction

    // Expected {x, x_valid, busy, done} t cycles after acceptance
    function automatic logic [3:0] exp_out(input int i, input int t, input int n);
        int w;
        int pos;
        int bitv;
        w = pw(i) + PAR;
        if (t < burst_len(i, n)) begin
            pos = t % (w + gp(i));
            if (pos < w) begin
                bitv = (pos < pw(i)) ? ((pat(i) >> (pw(i) - 1 - pos)) & 1) : par_bit(i);
                return {bitv[0], 3'b110};
            end
            return 4'b0010;
        end
        if (t == burst_len(i, n)) return 4'b0001;
        return 4'b0000;
    endfunction

    bit m_act [3];
    int m_t   [3];
    int m_n   [3];

    // Model: burst occupies len cycles + done cycle + one non-accepting idle cycle
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_act[i] = 1'b0;
            end else begin
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] > burst_len(i, m_n[i]) + 1) m_act[i] = 1'b0;
                end
                if (!m_act[i] && start) begin
                    m_act[i] = 1'b1;
                    m_t[i]   = 0;
                    m_n[i]   = (reps == 4'd0) ? 1 : int'(reps);
                end
            end
        end
    end

    function automatic logic [3:0] model_now(input int i);
        return m_act[i] ? exp_out(i, m_t[i], m_n[i]) : 4'b0000;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {x,v,busy,done}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        chk("u0_stream", {x0, v0, b0, d0}, model_now(0));
        chk("u1_stream", {x1, v1, b1, d1}, model_now(1));
        chk("u2_stream", {x2, v2, b2, d2}, model_now(2));
    end

    // Burst statistics of instance 0, cleared between directed tests
    int          cnt_valid;
    int          cnt_busy;
    int          cnt_done;
    logic [31:0] bits;

    always @(negedge clk) begin
        if (v0) begin
            cnt_valid++;
            bits = {bits[30:0], x0};
        end
        if (b0) cnt_busy++;
        if (d0) cnt_done++;
    end

    task automatic clear_stats();
        @(posedge clk);
        #1;
        cnt_valid = 0;
        cnt_busy  = 0;
        cnt_done  = 0;
        bits      = '0;
    endtask

    task automatic pulse_start(input logic [3:0] r);
        @(negedge clk);
        #1;
        start = 1'b1;
        reps  = r;
        @(negedge clk);
        #1;
        start = 1'b0;
        reps  = $urandom_range(0, 15);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got still busy want idle at %0t", $time);
        end
    endtask

    int k;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        reps    = 4'd0;
        bits    = '0;
        repeat (3) @(negedge clk);
        chk("reset_u0", {x0, v0, b0, d0}, 4'b0000);
        #1 reset_n = 1'b1;
        clear_stats();

        // Single repetition of the default pattern
        pulse_start(4'd1);
        wait_idle();
        chki("t1_valid", cnt_valid, 4 + PAR);
        chki("t1_bits", int'(bits), (PAR == 1) ? 'b01101 : 'b0110);
        chki("t1_busy", cnt_busy, 4 + PAR);
        chki("t1_done", cnt_done, 1);
        clear_stats();

        // Three repetitions with one gap cycle between
        pulse_start(4'd3);
        wait_idle();
        chki("t2_busy", cnt_busy, 3 * (4 + PAR) + 2);
        chki("t2_valid", cnt_valid, 3 * (4 + PAR));
        chki("t2_done", cnt_done, 1);
        clear_stats();

        // reps=0 behaves as one repetition
        pulse_start(4'd0);
        wait_idle();
        chki("t3_valid", cnt_valid, 4 + PAR);
        chki("t3_done", cnt_done, 1);
        clear_stats();

        // start held high: bursts only restart after DONE + IDLE
        @(negedge clk);
        #1;
        start = 1'b1;
        reps  = 4'd2;
        repeat (45) @(negedge clk);
        #1 start = 1'b0;
        wait_idle();
        chki("t4_valid_per_burst", cnt_valid % (2 * (4 + PAR)), 0);
        clear_stats();

        // Reset during the third bit of the second repetition
        pulse_start(4'd2);
        k = 0;
        while (!(m_act[0] && m_t[0] == (4 + PAR) + 1 + 2) && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        chki("t5_reached_bit", k < 50 ? 1 : 0, 1);
        chk("t5_third_bit", {x0, v0, b0, d0}, 4'b1110);
        reset_n = 1'b0;
        #1;
        chk("t5_async_zero", {x0, v0, b0, d0}, 4'b0000);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chki("t5_no_done", cnt_done, 0);
        clear_stats();
        pulse_start(4'd2);
        wait_idle();
        chki("t5_fresh_valid", cnt_valid, 2 * (4 + PAR));
        chki("t5_fresh_done", cnt_done, 1);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            reps  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                #1 reset_n = 1'b1;
            end
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
